// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_pkg
//  Purpose  : Shared encodings for the data-bus read interconnect: FSM state
//             codes, status register bit layout and the abort read value.
//  Revision : 1.0  initial release
// ============================================================================
package io_bus_pkg;

  // FSM state encoding, explicit 2-bit width
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_ABORT = 2'd2;

  // Status register layout: {coll_count[5:0], coll_flag, timeout_err}
  localparam int STATUS_TERR_BIT = 0;
  localparam int STATUS_COLL_BIT = 1;
  localparam int STATUS_CNT_LSB  = 2;

  // Value returned to the core when a hung access is aborted
  localparam logic [7:0] ABORT_DATA = 8'hFF;

  // Collision counter saturation point
  localparam logic [5:0] COLL_CNT_MAX = 6'd63;

  // Assemble the status byte from its fields
  function automatic logic [7:0] pack_status(input logic [5:0] cnt,
                                             input logic       coll,
                                             input logic       terr);
    return {cnt, coll, terr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_ctrl_if
//  Purpose  : Bundle of core-side and peripheral-side bus signals around the
//             read interconnect. The controller uses the slave view; the
//             core/peripheral side (or a bench) uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface io_bus_ctrl_if #(
  parameter int NR_OF_BUSSES_IN   = 4,
  parameter int BUS_ADDR_DATA_LEN = 14
);

  logic [BUS_ADDR_DATA_LEN-1:0]   addr;
  logic                           rd;
  logic                           wr;
  logic [7:0]                     bus_in;
  logic [NR_OF_BUSSES_IN-1:0]     slave_req;
  logic [NR_OF_BUSSES_IN*8-1:0]   slave_data;
  logic [NR_OF_BUSSES_IN-1:0]     slave_stall;
  logic [7:0]                     bus_out;
  logic                           stall;
  logic                           timeout_err;
  logic [BUS_ADDR_DATA_LEN-1:0]   err_addr;

  modport master (
    output addr, rd, wr, bus_in, slave_req, slave_data, slave_stall,
    input  bus_out, stall, timeout_err, err_addr
  );

  modport slave (
    input  addr, rd, wr, bus_in, slave_req, slave_data, slave_stall,
    output bus_out, stall, timeout_err, err_addr
  );

endinterface
`default_nettype wire

// File: rtl/io_bus_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_prio_sel
//  Purpose  : Combinational priority selector. Picks the lowest-index slave
//             with its request bit set, flags when more than one slave
//             claims the address at once.
//  Revision : 1.0  initial release
// ============================================================================
module io_bus_prio_sel #(
  parameter int NR_OF_BUSSES_IN = 4
) (
  input  wire logic [NR_OF_BUSSES_IN-1:0]   req,
  input  wire logic [NR_OF_BUSSES_IN*8-1:0] data,
  output logic                              valid,
  output logic                              collision,
  output logic [7:0]                        sel_data
);

  // Scan from highest to lowest index so the lowest set bit wins last
  always_comb begin
    valid    = 1'b0;
    sel_data = 8'h00;
    for (int i = NR_OF_BUSSES_IN - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid    = 1'b1;
        sel_data = data[i*8 +: 8];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  always_comb begin
    collision = |(req & (req - NR_OF_BUSSES_IN'(1)));
  end

endmodule
`default_nettype wire

// File: rtl/io_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_ctrl
//  Purpose  : Data-bus read interconnect between the core and N peripherals.
//             Priority-selects one slave, registers read data, merges stalls,
//             aborts hung accesses via a stall watchdog and exposes a status
//             register with W1C fields.
//  Revision : 1.0  initial release
// ============================================================================
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int                           NR_OF_BUSSES_IN   = 4,
  parameter int                           BUS_ADDR_DATA_LEN = 14,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] STATUS_ADDRESS    = 'h3F0,
  parameter int                           TIMEOUT_WIDTH     = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  io_bus_ctrl_if.slave bus
);

  localparam logic [TIMEOUT_WIDTH-1:0] C_CNT_MAX = '1;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [TIMEOUT_WIDTH-1:0]       r_cnt;

  logic [7:0]                     r_bus_out;
  logic                           r_timeout_err;
  logic [BUS_ADDR_DATA_LEN-1:0]   r_err_addr;
  logic                           r_coll_flag;
  logic [5:0]                     r_coll_cnt;

  logic                           w_stall;
  logic                           w_capture;
  logic                           w_abort;
  logic                           w_sel_valid;
  logic                           w_sel_coll;
  logic [7:0]                     w_sel_data;
  logic                           w_status_hit;
  logic [7:0]                     w_rd_data;
  logic                           w_coll_event;
  logic                           w_status_wr;

  io_bus_prio_sel #(
    .NR_OF_BUSSES_IN (NR_OF_BUSSES_IN)
  ) u_prio_sel (
    .req       (bus.slave_req),
    .data      (bus.slave_data),
    .valid     (w_sel_valid),
    .collision (w_sel_coll),
    .sel_data  (w_sel_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state: enter WAIT on a stalled access, abort once the counter
  // has reached its limit and the slave is still stalling
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_stall && (bus.rd || bus.wr)) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!w_stall)              w_next_state = ST_IDLE;
        else if (r_cnt == C_CNT_MAX) w_next_state = ST_ABORT;
      end
      ST_ABORT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: merged stall, read-completion strobe and abort strobe
  always_comb begin
    w_stall   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE, ST_WAIT: begin
        w_stall   = |bus.slave_stall;
        w_capture = !w_stall && bus.rd;
      end
      ST_ABORT: w_abort = 1'b1;
      default: ;
    endcase
  end

  // Stall watchdog: starts at 1 on entering WAIT, saturates, cleared on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && w_next_state == ST_WAIT) begin
      r_cnt <= TIMEOUT_WIDTH'(1);
    end else if (r_state == ST_WAIT && w_next_state == ST_WAIT) begin
      if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Read data source: status register beats any slave claiming the address
  always_comb begin
    w_status_hit = (bus.addr == STATUS_ADDRESS);
    if (w_status_hit)     w_rd_data = pack_status(r_coll_cnt, r_coll_flag, r_timeout_err);
    else if (w_sel_valid) w_rd_data = w_sel_data;
    else                  w_rd_data = 8'h00;
    w_coll_event = w_capture && !w_status_hit && w_sel_coll;
    w_status_wr  = bus.wr && !bus.rd && w_status_hit && !w_stall;
  end

  // Read data register: only completed reads or aborts update it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_bus_out <= 8'h00;
    else if (w_abort)   r_bus_out <= ABORT_DATA;
    else if (w_capture) r_bus_out <= w_rd_data;
  end

  // Timeout flag and faulting address; a new abort outranks a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
      r_err_addr    <= '0;
    end else if (w_abort) begin
      r_timeout_err <= 1'b1;
      r_err_addr    <= bus.addr;
    end else if (w_status_wr && bus.bus_in[STATUS_TERR_BIT]) begin
      r_timeout_err <= 1'b0;
    end
  end

  // Collision flag and saturating count; a new collision outranks a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll_flag <= 1'b0;
      r_coll_cnt  <= 6'd0;
    end else if (w_coll_event) begin
      r_coll_flag <= 1'b1;
      if (r_coll_cnt != COLL_CNT_MAX) r_coll_cnt <= r_coll_cnt + 6'd1;
    end else if (w_status_wr && bus.bus_in[STATUS_COLL_BIT]) begin
      r_coll_flag <= 1'b0;
      r_coll_cnt  <= 6'd0;
    end
  end

  // Stall is combinational, so gate it with reset to keep it low during reset
  assign bus.stall       = w_stall && !rst;
  assign bus.bus_out     = r_bus_out;
  assign bus.timeout_err = r_timeout_err;
  assign bus.err_addr    = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_bus_ctrl
//  Purpose  : Directed bench for io_bus_ctrl. Stimulus queues the expected
//             read byte; a monitor pops it when a read completes on the bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_bus_ctrl;

  localparam int              N    = 4;
  localparam int              AW   = 14;
  localparam int              TW   = 4;
  localparam logic [AW-1:0]   STAT = 14'h3F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_bus_ctrl_if #(.NR_OF_BUSSES_IN(N), .BUS_ADDR_DATA_LEN(AW)) bus ();

  io_bus_ctrl #(
    .NR_OF_BUSSES_IN   (N),
    .BUS_ADDR_DATA_LEN (AW),
    .STATUS_ADDRESS    (STAT),
    .TIMEOUT_WIDTH     (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       mon_done = 1'b0;
  int         n_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // A read completes at an edge where rd is high and the core sees no stall
  always @(posedge clk) mon_done <= bus.rd && !bus.stall && !rst;

  // Monitor: one cycle after completion the registered byte must match
  always @(negedge clk) begin
    if (mon_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected actual=%0h required=none", bus.bus_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.bus_out !== mon_exp) begin
          errors++;
          $display("FAIL read_data actual=%0h required=%0h", bus.bus_out, mon_exp);
        end
      end
    end
  end

  task automatic rd_single(input logic [AW-1:0] a, input logic [N-1:0] req, input logic [7:0] exp);
    @(negedge clk);
    bus.addr = a; bus.slave_req = req; bus.rd = 1'b1;
    exp_q.push_back(exp);
    #1 chk("read_no_stall", bus.stall, 0);
    @(negedge clk);
    bus.rd = 1'b0; bus.slave_req = '0;
  endtask

  task automatic wr_single(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.bus_in = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0; bus.bus_in = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.bus_in = 8'h00;
    bus.slave_req = '0; bus.slave_data = '0; bus.slave_stall = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_bus_out", bus.bus_out, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_terr", bus.timeout_err, 0);
    chk("reset_err_addr", bus.err_addr, 0);
    @(negedge clk); rst = 1'b0;

    // Plain read from slave 2
    bus.slave_data = {8'h04, 8'hA5, 8'h02, 8'h01};
    rd_single(14'h100, 4'b0100, 8'hA5);
    // A non-status write and idle cycles leave bus_out alone
    wr_single(14'h100, 8'hFF);
    @(negedge clk); #1 chk("hold_after_wr", bus.bus_out, 8'hA5);

    // Collision: slave 1 has priority over slave 2
    bus.slave_data = {8'h04, 8'h22, 8'h11, 8'h01};
    rd_single(14'h120, 4'b0110, 8'h11);
    // Status hit wins over a slave request: count=1, coll=1, terr=0
    rd_single(STAT, 4'b0001, 8'h06);

    // Slave 0 stalls for 5 cycles then returns 8'h3C
    @(negedge clk);
    bus.slave_data = {8'h04, 8'h22, 8'h11, 8'h3C};
    bus.addr = 14'h080; bus.slave_req = 4'b0001; bus.slave_stall = 4'b0001; bus.rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_high", bus.stall, 1);
      @(negedge clk);
    end
    bus.slave_stall = 4'b0000;
    exp_q.push_back(8'h3C);
    #1 chk("stall_released", bus.stall, 0);
    @(negedge clk);
    bus.rd = 1'b0; bus.slave_req = '0;
    #1 chk("no_timeout", bus.timeout_err, 0);

    // Stuck stall: issuing cycle plus 15 WAIT cycles, then the abort cycle
    @(negedge clk);
    bus.addr = 14'h201; bus.slave_req = 4'b0100; bus.slave_stall = 4'b0100; bus.rd = 1'b1;
    exp_q.push_back(8'hFF);
    n_stall = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!bus.stall) break;
      n_stall++;
      @(negedge clk);
    end
    chk("abort_stall_cycles", n_stall, 16);
    @(negedge clk);
    bus.rd = 1'b0; bus.slave_req = '0; bus.slave_stall = '0;
    #1;
    chk("abort_terr", bus.timeout_err, 1);
    chk("abort_err_addr", bus.err_addr, 14'h201);

    // Status W1C: clear timeout only, then collision only
    rd_single(STAT, 4'b0000, 8'h07);
    wr_single(STAT, 8'h01);
    #1 chk("w1c_terr", bus.timeout_err, 0);
    rd_single(STAT, 4'b0000, 8'h06);
    wr_single(STAT, 8'h02);
    #1 chk("hold_after_status_wr", bus.bus_out, 8'h06);
    rd_single(STAT, 4'b0000, 8'h00);

    // Reset in the middle of a stalled access
    bus.slave_data = {8'h5A, 8'h22, 8'h11, 8'h3C};
    rd_single(14'h150, 4'b1000, 8'h5A);
    @(negedge clk);
    bus.addr = 14'h151; bus.slave_req = 4'b0010; bus.slave_stall = 4'b0010; bus.rd = 1'b1;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_bus_out", bus.bus_out, 0);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_terr", bus.timeout_err, 0);
    chk("midrst_err_addr", bus.err_addr, 0);
    @(negedge clk);
    bus.rd = 1'b0; bus.slave_req = '0; bus.slave_stall = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("midrst_no_abort", bus.timeout_err, 0);
    rd_single(STAT, 4'b0000, 8'h00);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
